pipeline_hazard_unit: RTL and testbench
=======================================

Name: pipeline_hazard_unit

Overview:
- Parametrised hazard/forwarding controller for the 5-stage segmented RISC-V core (IF/ID/EX/MEM/WB).
- Replaces separate forwarding, load-use and clear-pipeline logic with one block.
- Adds a multi-cycle load-use bubble, data-memory wait-state freezing, a taken-branch flush and a saturating stall counter.

Parameters:
- REG_ADDR_BITS, 5, register address width.
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..3).
- MEM_WAIT_CYCLES, 0, data-memory wait states per access; 0 disables MEM_WAIT.
- FORWARDING_EN, 1, 1 = MEM/WB bypass enabled; 0 = forward1/forward2 forced to 00.
- COUNT_BITS, 16, stall_count width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- rs1_addr_id, rs2_addr_id  in  REG_ADDR_BITS  sources of the instruction in IF/ID.
- rs1_addr_ex, rs2_addr_ex  in  REG_ADDR_BITS  sources of the instruction in ID/EX.
- rd_addr_ex  in  REG_ADDR_BITS  destination in ID/EX.
- mem_read_ex  in  1  the instruction in ID/EX is a load.
- rd_addr_mem  in  REG_ADDR_BITS  destination in EX/MEM.
- reg_write_mem  in  1  EX/MEM writes rd.
- rd_addr_wb  in  REG_ADDR_BITS  destination in MEM/WB.
- reg_write_wb  in  1  MEM/WB writes rd.
- mem_access_mem  in  1  EX/MEM holds a load or store.
- branch_taken_mem  in  1  branch or jump resolved taken in MEM.
- forward1, forward2  out  2  00 = register file, 10 = EX/MEM ALU result, 01 = WB value.
- pc_write  out  1  PC enable.
- if_id_write  out  1  IF/ID enable.
- id_ex_bubble  out  1  zero the ID/EX control fields.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  synchronous clear of the register at the next edge.
- freeze  out  1  hold all four pipeline registers and the PC.
- state  out  2  00 RUN, 01 LOAD_STALL, 10 MEM_WAIT.
- stall_count  out  COUNT_BITS  cycles in which pc_write was 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = RUN, internal counters = 0, stall_count = 0.
  - Outputs: pc_write=1, if_id_write=1, all flush/bubble/freeze = 0, forward* = 00.
- Forwarding (combinational, every state):
  - forward1 = 10 if reg_write_mem and rd_addr_mem != 0 and rd_addr_mem == rs1_addr_ex.
  - Else 01 if reg_write_wb and rd_addr_wb != 0 and rd_addr_wb == rs1_addr_ex.
  - Else 00. MEM beats WB.
  - forward2 uses the same rule with rs2_addr_ex.
- Load-use detection:
  - hazard = mem_read_ex and rd_addr_ex != 0 and (rd_addr_ex == rs1_addr_id or rd_addr_ex == rs2_addr_id).
- RUN, priority order:
  1. branch_taken_mem: assert if_id_flush, id_ex_flush, ex_mem_flush combinationally this cycle; pc_write stays 1; stay in RUN. Any load-use hazard this cycle is ignored.
  2. mem_access_mem and MEM_WAIT_CYCLES > 0: freeze=1, pc_write=0, if_id_write=0 this cycle; wait counter = MEM_WAIT_CYCLES-1; go to MEM_WAIT.
  3. hazard: pc_write=0, if_id_write=0, id_ex_bubble=1 this cycle; bubble counter = LOAD_USE_BUBBLES-1. Go to LOAD_STALL if that value > 0, else stay in RUN.
- MEM_WAIT:
  - freeze=1, pc_write=0, if_id_write=0; all flush and bubble outputs are 0.
  - Decrement the wait counter; leave for RUN when it is 0.
  - Total freeze length = exactly MEM_WAIT_CYCLES cycles per access.
  - The instruction in EX/MEM is frozen, so mem_access_mem stays high. After returning to RUN, that same access must not retrigger: a one-shot done flag is set on exit and cleared when EX/MEM advances (first cycle with pc_write=1).
- LOAD_STALL:
  - pc_write=0, if_id_write=0, id_ex_bubble=1; decrement the bubble counter; go to RUN at 0.
  - A load-use hazard is inserted for LOAD_USE_BUBBLES cycles total.
  - A branch_taken_mem arriving here flushes as in RUN and aborts to RUN the same edge; flush beats bubble.
- stall_count:
  - Increments on every rising edge where pc_write=0 and reset=1.
  - Saturates at all-ones; no wrap.
- Reset asserted mid-stall or mid-wait: immediate return to RUN with all counters cleared; no residual freeze after release.
- Outputs other than state and stall_count are combinational from the inputs and registered state. Zero-cycle latency for hazard response.
- state value 11 is unreachable; if entered, the FSM returns to RUN next cycle.

Test Plan:
- Forwarding: reg_write_mem=1, rd_addr_mem=5, reg_write_wb=1, rd_addr_wb=5, rs1_addr_ex=5 -> forward1=10. Set rd_addr_mem=0 -> forward1=01. Set rs2_addr_ex=0 with rd_addr_wb=0 -> forward2=00.
- Load-use with LOAD_USE_BUBBLES=2: mem_read_ex=1, rd_addr_ex=7, rs2_addr_id=7 -> pc_write=0 and id_ex_bubble=1 for exactly 2 cycles, state 00->01->00, stall_count=2.
- Memory wait with MEM_WAIT_CYCLES=3: mem_access_mem held high -> freeze=1 for exactly 3 cycles, then pc_write=1 with no retrigger, stall_count +3.
- Branch during stall: enter LOAD_STALL (LOAD_USE_BUBBLES=3), assert branch_taken_mem on its 2nd cycle -> all three flushes=1 that cycle, state=RUN next cycle, id_ex_bubble=0.
- Reset mid-MEM_WAIT: drive reset=0 asynchronously in cycle 2 of 3 -> state=00, freeze=0 and stall_count=0 immediately, before the next clk edge.
- Saturation with COUNT_BITS=4: 20 forced stall cycles -> stall_count=15 and stays at 15.

Source files
------------

// File: rtl/pipeline_hazard_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard/forwarding controller.
// The datapath side uses master; the controller uses slave.
interface pipeline_hazard_unit_if #(
  parameter int REG_ADDR_BITS = 5,
  parameter int COUNT_BITS    = 16
);
  logic [REG_ADDR_BITS-1:0] rs1_addr_id;
  logic [REG_ADDR_BITS-1:0] rs2_addr_id;
  logic [REG_ADDR_BITS-1:0] rs1_addr_ex;
  logic [REG_ADDR_BITS-1:0] rs2_addr_ex;
  logic [REG_ADDR_BITS-1:0] rd_addr_ex;
  logic                     mem_read_ex;
  logic [REG_ADDR_BITS-1:0] rd_addr_mem;
  logic                     reg_write_mem;
  logic [REG_ADDR_BITS-1:0] rd_addr_wb;
  logic                     reg_write_wb;
  logic                     mem_access_mem;
  logic                     branch_taken_mem;

  logic [1:0]               forward1;
  logic [1:0]               forward2;
  logic                     pc_write;
  logic                     if_id_write;
  logic                     id_ex_bubble;
  logic                     if_id_flush;
  logic                     id_ex_flush;
  logic                     ex_mem_flush;
  logic                     freeze;
  logic [1:0]               state;
  logic [COUNT_BITS-1:0]    stall_count;

  modport master (
    output rs1_addr_id, rs2_addr_id, rs1_addr_ex, rs2_addr_ex, rd_addr_ex, mem_read_ex,
           rd_addr_mem, reg_write_mem, rd_addr_wb, reg_write_wb, mem_access_mem, branch_taken_mem,
    input  forward1, forward2, pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
           ex_mem_flush, freeze, state, stall_count
  );

  modport slave (
    input  rs1_addr_id, rs2_addr_id, rs1_addr_ex, rs2_addr_ex, rd_addr_ex, mem_read_ex,
           rd_addr_mem, reg_write_mem, rd_addr_wb, reg_write_wb, mem_access_mem, branch_taken_mem,
    output forward1, forward2, pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
           ex_mem_flush, freeze, state, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage core: MEM/WB bypass select, multi-cycle
// load-use bubbles, data-memory wait-state freeze, taken-branch flush and a saturating stall counter.
module pipeline_hazard_unit #(
  parameter int REG_ADDR_BITS    = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MEM_WAIT_CYCLES  = 0,
  parameter int FORWARDING_EN    = 1,
  parameter int COUNT_BITS       = 16
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_unit_if.slave hz
);

  localparam logic [1:0] RUN        = 2'b00;
  localparam logic [1:0] LOAD_STALL = 2'b01;
  localparam logic [1:0] MEM_WAIT   = 2'b10;

  localparam int              WAIT_W      = (MEM_WAIT_CYCLES > 2) ? $clog2(MEM_WAIT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((MEM_WAIT_CYCLES > 0) ? MEM_WAIT_CYCLES - 1 : 0);
  localparam logic [1:0]      BUBBLE_LOAD = 2'(LOAD_USE_BUBBLES - 1);
  localparam bit              WAIT_EN     = (MEM_WAIT_CYCLES > 0);
  localparam bit              FWD_EN      = (FORWARDING_EN != 0);

  logic [1:0]            state_reg, state_next;
  logic [1:0]            bubble_cnt_reg, bubble_cnt_next;
  logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
  logic                  done_reg, done_next;
  logic [COUNT_BITS-1:0] stall_count_reg, stall_count_next;

  logic       hazard;
  logic       mem_trigger;
  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_bubble;
  logic       flush_all;
  logic       freeze;
  logic [1:0] forward1;
  logic [1:0] forward2;

  // MEM result is newer than WB, so it wins when both match; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_BITS-1:0] src, mem_rd, wb_rd,
                                         input logic mem_we, wb_we);
    if (mem_we && (mem_rd != '0) && (mem_rd == src)) return 2'b10;
    if (wb_we && (wb_rd != '0) && (wb_rd == src))    return 2'b01;
    return 2'b00;
  endfunction

  assign hazard = hz.mem_read_ex && (hz.rd_addr_ex != '0) &&
                  ((hz.rd_addr_ex == hz.rs1_addr_id) || (hz.rd_addr_ex == hz.rs2_addr_id));

  // done_reg stops the access that just finished its wait from starting a second one.
  assign mem_trigger = WAIT_EN && hz.mem_access_mem && !done_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= RUN;
      bubble_cnt_reg  <= '0;
      wait_cnt_reg    <= '0;
      done_reg        <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      bubble_cnt_reg  <= bubble_cnt_next;
      wait_cnt_reg    <= wait_cnt_next;
      done_reg        <= done_next;
      stall_count_reg <= stall_count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bubble_cnt_next = bubble_cnt_reg;
    wait_cnt_next   = wait_cnt_reg;
    done_next       = done_reg;
    // EX/MEM advances whenever the PC does, which retires the finished access.
    if (pc_write) done_next = 1'b0;
    case (state_reg)
      RUN: begin
        if (hz.branch_taken_mem) begin
          state_next = RUN;
        end else if (mem_trigger) begin
          wait_cnt_next = WAIT_LOAD;
          if (WAIT_LOAD == '0) done_next  = 1'b1;
          else                 state_next = MEM_WAIT;
        end else if (hazard) begin
          bubble_cnt_next = BUBBLE_LOAD;
          if (BUBBLE_LOAD != 2'd0) state_next = LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        if (hz.branch_taken_mem) begin
          bubble_cnt_next = 2'd0;
          state_next      = RUN;
        end else begin
          bubble_cnt_next = bubble_cnt_reg - 2'd1;
          if (bubble_cnt_reg <= 2'd1) state_next = RUN;
        end
      end
      MEM_WAIT: begin
        wait_cnt_next = wait_cnt_reg - WAIT_W'(1);
        if (wait_cnt_reg <= WAIT_W'(1)) begin
          state_next = RUN;
          done_next  = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
    stall_count_next = stall_count_reg;
    if (!pc_write && (stall_count_reg != {COUNT_BITS{1'b1}}))
      stall_count_next = stall_count_reg + COUNT_BITS'(1);
  end

  // While reset is held every control output is forced idle, even with hazards on the inputs.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    flush_all    = 1'b0;
    freeze       = 1'b0;
    forward1     = 2'b00;
    forward2     = 2'b00;
    if (reset) begin
      if (FWD_EN) begin
        forward1 = fwd_sel(hz.rs1_addr_ex, hz.rd_addr_mem, hz.rd_addr_wb, hz.reg_write_mem, hz.reg_write_wb);
        forward2 = fwd_sel(hz.rs2_addr_ex, hz.rd_addr_mem, hz.rd_addr_wb, hz.reg_write_mem, hz.reg_write_wb);
      end
      case (state_reg)
        RUN: begin
          if (hz.branch_taken_mem) begin
            flush_all = 1'b1;
          end else if (mem_trigger) begin
            freeze      = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
          end else if (hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        LOAD_STALL: begin
          if (hz.branch_taken_mem) begin
            flush_all = 1'b1;
          end else begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          freeze      = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign hz.forward1     = forward1;
  assign hz.forward2     = forward2;
  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.if_id_flush  = flush_all;
  assign hz.id_ex_flush  = flush_all;
  assign hz.ex_mem_flush = flush_all;
  assign hz.freeze       = freeze;
  assign hz.state        = state_reg;
  assign hz.stall_count  = stall_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Three differently parameterised hazard units share one random stimulus stream and are
// checked every cycle against a remaining-cycles reference model, plus directed literal checks.
module tb_pipeline_hazard_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex;
    logic       mem_read;
    logic [4:0] rd_mem;
    logic       rwm;
    logic [4:0] rd_wb;
    logic       rww;
    logic       mem_acc;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic [1:0]  f1, f2;
    logic        pc, ifid, bub, fl1, fl2, fl3, frz;
    logic [1:0]  st;
    logic [15:0] cnt;
  } obs_t;

  stim_t stim = '0;
  obs_t  obs[3];

  // Instance configs: u0 (bubbles 2, wait 3), u1 (bubbles 3, no wait, 4-bit count), u2 (bubbles 1, wait 1, no bypass)
  int LUB[3]  = '{2, 3, 1};
  int MWC[3]  = '{3, 0, 1};
  int FWD[3]  = '{1, 1, 0};
  int CMAX[3] = '{65535, 15, 65535};

  pipeline_hazard_unit_if #(.REG_ADDR_BITS(5), .COUNT_BITS(16)) if0 ();
  pipeline_hazard_unit_if #(.REG_ADDR_BITS(5), .COUNT_BITS(4))  if1 ();
  pipeline_hazard_unit_if #(.REG_ADDR_BITS(5), .COUNT_BITS(16)) if2 ();

  pipeline_hazard_unit #(.REG_ADDR_BITS(5), .LOAD_USE_BUBBLES(2), .MEM_WAIT_CYCLES(3), .FORWARDING_EN(1), .COUNT_BITS(16))
    u0 (.clk(clk), .reset(reset), .hz(if0));
  pipeline_hazard_unit #(.REG_ADDR_BITS(5), .LOAD_USE_BUBBLES(3), .MEM_WAIT_CYCLES(0), .FORWARDING_EN(1), .COUNT_BITS(4))
    u1 (.clk(clk), .reset(reset), .hz(if1));
  pipeline_hazard_unit #(.REG_ADDR_BITS(5), .LOAD_USE_BUBBLES(1), .MEM_WAIT_CYCLES(1), .FORWARDING_EN(0), .COUNT_BITS(16))
    u2 (.clk(clk), .reset(reset), .hz(if2));

  assign {if0.rs1_addr_id, if0.rs2_addr_id, if0.rs1_addr_ex, if0.rs2_addr_ex, if0.rd_addr_ex, if0.mem_read_ex, if0.rd_addr_mem, if0.reg_write_mem, if0.rd_addr_wb, if0.reg_write_wb, if0.mem_access_mem, if0.branch_taken_mem} = stim;
  assign {if1.rs1_addr_id, if1.rs2_addr_id, if1.rs1_addr_ex, if1.rs2_addr_ex, if1.rd_addr_ex, if1.mem_read_ex, if1.rd_addr_mem, if1.reg_write_mem, if1.rd_addr_wb, if1.reg_write_wb, if1.mem_access_mem, if1.branch_taken_mem} = stim;
  assign {if2.rs1_addr_id, if2.rs2_addr_id, if2.rs1_addr_ex, if2.rs2_addr_ex, if2.rd_addr_ex, if2.mem_read_ex, if2.rd_addr_mem, if2.reg_write_mem, if2.rd_addr_wb, if2.reg_write_wb, if2.mem_access_mem, if2.branch_taken_mem} = stim;

  assign obs[0] = {if0.forward1, if0.forward2, if0.pc_write, if0.if_id_write, if0.id_ex_bubble, if0.if_id_flush, if0.id_ex_flush, if0.ex_mem_flush, if0.freeze, if0.state, if0.stall_count};
  assign obs[1] = {if1.forward1, if1.forward2, if1.pc_write, if1.if_id_write, if1.id_ex_bubble, if1.if_id_flush, if1.id_ex_flush, if1.ex_mem_flush, if1.freeze, if1.state, 12'd0, if1.stall_count};
  assign obs[2] = {if2.forward1, if2.forward2, if2.pc_write, if2.if_id_write, if2.id_ex_bubble, if2.if_id_flush, if2.id_ex_flush, if2.ex_mem_flush, if2.freeze, if2.state, if2.stall_count};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s u%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference model: remaining stall/freeze cycles, a served-access flag and a saturating count.
  int bub_left[3] = '{0, 0, 0};
  int frz_left[3] = '{0, 0, 0};
  bit served[3]   = '{0, 0, 0};
  int cnt[3]      = '{0, 0, 0};

  function automatic logic [1:0] exp_fwd(input int k, input logic [4:0] src);
    if (FWD[k] == 0) return 2'b00;
    if (stim.rwm && stim.rd_mem != 0 && stim.rd_mem == src) return 2'b10;
    if (stim.rww && stim.rd_wb != 0 && stim.rd_wb == src)   return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit load_use();
    return stim.mem_read && stim.rd_ex != 0 && (stim.rd_ex == stim.rs1_id || stim.rd_ex == stim.rs2_id);
  endfunction

  logic [1:0] e_f1, e_f2, e_st;
  bit         e_pc, e_bub, e_fl, e_frz;
  int         nf;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      e_f1 = 2'b00; e_f2 = 2'b00; e_st = 2'b00;
      e_pc = 1'b1; e_bub = 1'b0; e_fl = 1'b0; e_frz = 1'b0;
      if (!reset) begin
        bub_left[k] = 0; frz_left[k] = 0; served[k] = 1'b0; cnt[k] = 0;
      end else begin
        e_f1 = exp_fwd(k, stim.rs1_ex);
        e_f2 = exp_fwd(k, stim.rs2_ex);
        if (frz_left[k] > 0) begin
          e_frz = 1'b1; e_pc = 1'b0; e_st = 2'd2;
        end else if (bub_left[k] > 0) begin
          e_st = 2'd1;
          if (stim.br) e_fl = 1'b1;
          else begin e_bub = 1'b1; e_pc = 1'b0; end
        end else if (stim.br) begin
          e_fl = 1'b1;
        end else if (stim.mem_acc && MWC[k] > 0 && !served[k]) begin
          e_frz = 1'b1; e_pc = 1'b0;
        end else if (load_use()) begin
          e_bub = 1'b1; e_pc = 1'b0;
        end
      end
      chk("forward1", k, obs[k].f1, e_f1);
      chk("forward2", k, obs[k].f2, e_f2);
      chk("pc_write", k, obs[k].pc, e_pc);
      chk("if_id_write", k, obs[k].ifid, e_pc);
      chk("id_ex_bubble", k, obs[k].bub, e_bub);
      chk("if_id_flush", k, obs[k].fl1, e_fl);
      chk("id_ex_flush", k, obs[k].fl2, e_fl);
      chk("ex_mem_flush", k, obs[k].fl3, e_fl);
      chk("freeze", k, obs[k].frz, e_frz);
      chk("state", k, obs[k].st, e_st);
      chk("stall_count", k, obs[k].cnt, cnt[k]);
      if (reset) begin
        if (e_pc) served[k] = 1'b0;
        if (e_frz) begin
          nf = (frz_left[k] > 0) ? frz_left[k] - 1 : MWC[k] - 1;
          if (nf == 0) served[k] = 1'b1;
          frz_left[k] = nf;
        end
        if (bub_left[k] > 0) bub_left[k] = stim.br ? 0 : bub_left[k] - 1;
        else if (e_bub)      bub_left[k] = LUB[k] - 1;
        if (!e_pc && cnt[k] < CMAX[k]) cnt[k]++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    cyc(); reset = 1'b0; stim = '0;
    cyc(); reset = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    stim.mem_read = 1'b1; stim.rd_ex = rd; stim.rs2_id = rd;
  endtask

  initial begin
    // Reset held with a hazard and a memory access on the inputs: outputs must stay idle.
    stim.mem_acc = 1'b1; set_load_use(5'd7);
    mid();
    chk("lit_reset_pc_write", 0, obs[0].pc, 1);
    chk("lit_reset_freeze", 0, obs[0].frz, 0);
    chk("lit_reset_bubble", 1, obs[1].bub, 0);
    chk("lit_reset_state", 0, obs[0].st, 0);
    chk("lit_reset_count", 0, obs[0].cnt, 0);
    cyc(); reset = 1'b1; stim = '0;

    // Forwarding priority and x0 exclusion.
    cyc(); stim.rwm = 1'b1; stim.rd_mem = 5'd5; stim.rww = 1'b1; stim.rd_wb = 5'd5; stim.rs1_ex = 5'd5; stim.rs2_ex = 5'd9;
    mid();
    chk("lit_fwd1_mem", 0, obs[0].f1, 2);
    chk("lit_fwd_disabled", 2, obs[2].f1, 0);
    chk("lit_fwd2_nomatch", 0, obs[0].f2, 0);
    cyc(); stim.rd_mem = 5'd0;
    mid();
    chk("lit_fwd1_wb", 0, obs[0].f1, 1);
    cyc(); stim.rs2_ex = 5'd0; stim.rd_wb = 5'd0;
    mid();
    chk("lit_fwd2_x0", 0, obs[0].f2, 0);
    cyc(); stim.rd_mem = 5'd3; stim.rs2_ex = 5'd3;
    mid();
    chk("lit_fwd2_mem", 1, obs[1].f2, 2);

    // Load-use: two bubbles on u0, three on u1, one per hazard cycle on u2.
    do_reset();
    cyc(); set_load_use(5'd7);
    mid();
    chk("lit_lu_pc_c1", 0, obs[0].pc, 0);
    chk("lit_lu_bub_c1", 0, obs[0].bub, 1);
    chk("lit_lu_state_c1", 0, obs[0].st, 0);
    cyc();
    mid();
    chk("lit_lu_bub_c2", 0, obs[0].bub, 1);
    chk("lit_lu_state_c2", 0, obs[0].st, 1);
    cyc(); stim = '0;
    mid();
    chk("lit_lu_pc_c3", 0, obs[0].pc, 1);
    chk("lit_lu_state_c3", 0, obs[0].st, 0);
    chk("lit_lu_count", 0, obs[0].cnt, 2);
    cyc();
    mid();
    chk("lit_lu3_count", 1, obs[1].cnt, 3);
    chk("lit_lu3_state", 1, obs[1].st, 0);
    chk("lit_lu1_count", 2, obs[2].cnt, 2);

    // Memory wait: three frozen cycles, then one free cycle with the access still present.
    do_reset();
    cyc(); stim.mem_acc = 1'b1;
    mid();
    chk("lit_mw_freeze_c1", 0, obs[0].frz, 1);
    chk("lit_mw_state_c1", 0, obs[0].st, 0);
    cyc();
    mid();
    chk("lit_mw_state_c2", 0, obs[0].st, 2);
    chk("lit_mw1_noretrigger", 2, obs[2].frz, 0);
    cyc();
    mid();
    chk("lit_mw_freeze_c3", 0, obs[0].frz, 1);
    cyc();
    mid();
    chk("lit_mw_freeze_c4", 0, obs[0].frz, 0);
    chk("lit_mw_pc_c4", 0, obs[0].pc, 1);
    chk("lit_mw_count", 0, obs[0].cnt, 3);
    chk("lit_mw_disabled", 1, obs[1].frz, 0);
    cyc(); stim = '0;

    // Taken branch during the load-use stall.
    do_reset();
    cyc(); stim.mem_read = 1'b1; stim.rd_ex = 5'd7; stim.rs1_id = 5'd7;
    mid();
    chk("lit_br_bub_c1", 1, obs[1].bub, 1);
    cyc(); stim = '0; stim.br = 1'b1;
    mid();
    chk("lit_br_state_c2", 1, obs[1].st, 1);
    chk("lit_br_flush", 1, {29'd0, obs[1].fl1, obs[1].fl2, obs[1].fl3}, 7);
    chk("lit_br_bub_c2", 1, obs[1].bub, 0);
    cyc(); stim.br = 1'b0;
    mid();
    chk("lit_br_state_c3", 1, obs[1].st, 0);
    chk("lit_br_bub_c3", 1, obs[1].bub, 0);

    // Asynchronous reset in the middle of the memory wait.
    do_reset();
    cyc(); stim.mem_acc = 1'b1;
    cyc();
    chk("lit_ar_state_before", 0, obs[0].st, 2);
    #1 reset = 1'b0;
    #1;
    chk("lit_ar_state", 0, obs[0].st, 0);
    chk("lit_ar_freeze", 0, obs[0].frz, 0);
    chk("lit_ar_count", 0, obs[0].cnt, 0);
    cyc(); reset = 1'b1; stim = '0;
    mid();
    chk("lit_ar_after", 0, obs[0].frz, 0);

    // Saturation of the 4-bit stall counter.
    do_reset();
    cyc(); set_load_use(5'd9);
    repeat (19) cyc();
    mid();
    chk("lit_sat_count", 1, obs[1].cnt, 15);
    cyc();
    mid();
    chk("lit_sat_hold", 1, obs[1].cnt, 15);
    cyc(); stim = '0;

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset = 1'b1;
      stim.rs1_id   = 5'($urandom_range(0, 3));
      stim.rs2_id   = 5'($urandom_range(0, 3));
      stim.rs1_ex   = 5'($urandom_range(0, 3));
      stim.rs2_ex   = 5'($urandom_range(0, 3));
      stim.rd_ex    = 5'($urandom_range(0, 3));
      stim.rd_mem   = 5'($urandom_range(0, 3));
      stim.rd_wb    = 5'($urandom_range(0, 3));
      stim.mem_read = ($urandom_range(0, 2) == 0);
      stim.rwm      = ($urandom_range(0, 1) == 0);
      stim.rww      = ($urandom_range(0, 1) == 0);
      stim.mem_acc  = ($urandom_range(0, 5) == 0);
      stim.br       = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 reset = 1'b0;
      end
    end

    cyc(); reset = 1'b1; stim = '0;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
